line_cmd_sequencer: RTL and testbench

Upstream command stage for the line drawer (line_drawer_control/line_drawer_data pair). It buffers line requests (endpoints + colour) in a small FIFO and issues them one at a time over the drawer's level start/done handshake. Presents x0/y0/x1/y1/colour to the drawer and guarantees start is released between lines so the drawer returns to idle. Output side feeds the drawer; drawer pixel output continues to the VGA adapter.

---
 rtl/line_pkg.sv | 29 ++
 rtl/line_cmd_fifo.sv | 57 +++++
 rtl/line_cmd_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_line_cmd_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_pkg.sv
// Shared types and widths for the line command sequencer.
// Optional macro CLEAR_SCREEN_EN adds the CLEAR state used by the screen-clear sweep.
package line_pkg;

  localparam int unsigned X_W = 9;
  localparam int unsigned Y_W = 8;
  localparam int unsigned C_W = 3;

  // One queued line request: endpoints plus colour (37 bits).
  typedef struct packed {
    logic [X_W-1:0] x0;
    logic [Y_W-1:0] y0;
    logic [X_W-1:0] x1;
    logic [Y_W-1:0] y1;
    logic [C_W-1:0] colour;
  } line_cmd_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_DONE = 3'd2,
    RELEASE   = 3'd3
`ifdef CLEAR_SCREEN_EN
    ,
    CLEAR     = 3'd4
`endif
  } seq_state_t;

endpackage

// File: rtl/line_cmd_fifo.sv
// Synchronous FIFO of line commands; head entry is visible combinationally on rd_data.
module line_cmd_fifo
  import line_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  line_cmd_t               wr_data,
  input  logic                    pop,
  output line_cmd_t               rd_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  line_cmd_t          mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic               do_push;
  logic               do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];
  assign count   = count_q;

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/line_cmd_sequencer.sv
// Buffers line requests and issues them one at a time to the line drawer over a
// level start/done handshake, forcing start low between lines.
// Optional macro CLEAR_SCREEN_EN adds a full-screen clear sweep on the pixel path.
module line_cmd_sequencer
  import line_pkg::*;
#(
  parameter int unsigned DEPTH = 4
`ifdef CLEAR_SCREEN_EN
  ,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [X_W-1:0]          cmd_x0,
  input  logic [Y_W-1:0]          cmd_y0,
  input  logic [X_W-1:0]          cmd_x1,
  input  logic [Y_W-1:0]          cmd_y1,
  input  logic [C_W-1:0]          cmd_colour,
  output logic                    ld_start,
  output logic [X_W-1:0]          ld_x0,
  output logic [Y_W-1:0]          ld_y0,
  output logic [X_W-1:0]          ld_x1,
  output logic [Y_W-1:0]          ld_y1,
  output logic [C_W-1:0]          ld_colour,
  input  logic                    ld_done,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [15:0]             lines_drawn
`ifdef CLEAR_SCREEN_EN
  ,
  input  logic                    clear_req,
  output logic [X_W-1:0]          pix_x,
  output logic [Y_W-1:0]          pix_y,
  output logic [C_W-1:0]          pix_colour,
  output logic                    pix_plot,
  input  logic [X_W-1:0]          drw_x,
  input  logic [Y_W-1:0]          drw_y,
  input  logic [C_W-1:0]          drw_colour,
  input  logic                    drw_plot
`endif
);

  seq_state_t state_q;
  seq_state_t state_d;
  logic       ld_start_d;
  logic       pop;
  logic       line_done;
  logic       fifo_full;
  logic       fifo_empty;
  line_cmd_t  cmd_in;
  line_cmd_t  fifo_head;
  line_cmd_t  ld_cmd_q;

`ifdef CLEAR_SCREEN_EN
  logic [X_W-1:0] clr_x;
  logic [X_W-1:0] clr_x_d;
  logic [Y_W-1:0] clr_y;
  logic [Y_W-1:0] clr_y_d;
  logic           in_clear;
`endif

  assign cmd_in = '{x0: cmd_x0, y0: cmd_y0, x1: cmd_x1, y1: cmd_y1, colour: cmd_colour};

  // Ready depends only on occupancy, so a pop in the same cycle cannot unblock a full FIFO.
  assign cmd_ready = ~fifo_full;

  line_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (cmd_valid & cmd_ready),
    .wr_data (cmd_in),
    .pop     (pop),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Next-state logic; ld_start_d is the value ld_start takes after this edge.
  always_comb begin
    state_d    = state_q;
    ld_start_d = 1'b0;
    pop        = 1'b0;
    line_done  = 1'b0;
`ifdef CLEAR_SCREEN_EN
    clr_x_d    = clr_x;
    clr_y_d    = clr_y;
`endif
    case (state_q)
      IDLE: begin
`ifdef CLEAR_SCREEN_EN
        if (clear_req) begin
          state_d = CLEAR;
          clr_x_d = '0;
          clr_y_d = '0;
        end else
`endif
        if (!fifo_empty) begin
          pop        = 1'b1;
          ld_start_d = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        ld_start_d = 1'b1;
        state_d    = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (ld_done) begin
          line_done = 1'b1;
          state_d   = RELEASE;
        end else begin
          ld_start_d = 1'b1;
        end
      end
      RELEASE: begin
        if (!ld_done) state_d = IDLE;
      end
`ifdef CLEAR_SCREEN_EN
      CLEAR: begin
        if (clr_x == X_W'(SCREEN_W - 1)) begin
          clr_x_d = '0;
          if (clr_y == Y_W'(SCREEN_H - 1)) begin
            clr_y_d = '0;
            state_d = IDLE;
          end else begin
            clr_y_d = clr_y + Y_W'(1);
          end
        end else begin
          clr_x_d = clr_x + X_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and start registers; reset drops start immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ld_start <= 1'b0;
    end else begin
      state_q  <= state_d;
      ld_start <= ld_start_d;
    end
  end

  // Command presented to the drawer; held from one pop until the next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cmd_q <= '0;
    end else if (pop) begin
      ld_cmd_q <= fifo_head;
    end
  end

  // Completed-line counter, wraps at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lines_drawn <= '0;
    end else if (line_done) begin
      lines_drawn <= lines_drawn + 16'd1;
    end
  end

  assign ld_x0     = ld_cmd_q.x0;
  assign ld_y0     = ld_cmd_q.y0;
  assign ld_x1     = ld_cmd_q.x1;
  assign ld_y1     = ld_cmd_q.y1;
  assign ld_colour = ld_cmd_q.colour;
  assign busy      = (state_q != IDLE) | ~fifo_empty;

`ifdef CLEAR_SCREEN_EN
  // Sweep position: x inner, y outer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_x <= '0;
      clr_y <= '0;
    end else begin
      clr_x <= clr_x_d;
      clr_y <= clr_y_d;
    end
  end

  // Pixel path: clear sweep overrides the drawer only while in CLEAR.
  assign in_clear   = (state_q == CLEAR);
  assign pix_x      = in_clear ? clr_x : drw_x;
  assign pix_y      = in_clear ? clr_y : drw_y;
  assign pix_colour = in_clear ? '0    : drw_colour;
  assign pix_plot   = in_clear ? 1'b1  : drw_plot;
`endif

endmodule

// File: tb/tb_line_cmd_sequencer.sv
// Directed self-checking bench for line_cmd_sequencer (default build, DEPTH=4).
module tb_line_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [8:0] cmd_x0;
  logic [7:0] cmd_y0;
  logic [8:0] cmd_x1;
  logic [7:0] cmd_y1;
  logic [2:0] cmd_colour;
  logic       ld_start;
  logic [8:0] ld_x0;
  logic [7:0] ld_y0;
  logic [8:0] ld_x1;
  logic [7:0] ld_y1;
  logic [2:0] ld_colour;
  logic       ld_done;
  logic       busy;
  logic [2:0] fifo_count;
  logic [15:0] lines_drawn;

  int checks   = 0;
  int failures = 0;
  int exp_lines = 0;

  line_cmd_sequencer #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_x0      (cmd_x0),
    .cmd_y0      (cmd_y0),
    .cmd_x1      (cmd_x1),
    .cmd_y1      (cmd_y1),
    .cmd_colour  (cmd_colour),
    .ld_start    (ld_start),
    .ld_x0       (ld_x0),
    .ld_y0       (ld_y0),
    .ld_x1       (ld_x1),
    .ld_y1       (ld_y1),
    .ld_colour   (ld_colour),
    .ld_done     (ld_done),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .lines_drawn (lines_drawn)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int x0, input int y0, input int x1, input int y1, input int col);
    cmd_x0     = 9'(x0);
    cmd_y0     = 8'(y0);
    cmd_x1     = 9'(x1);
    cmd_y1     = 8'(y1);
    cmd_colour = 3'(col);
  endtask

  // Offer one command for exactly one edge.
  task automatic push(input int x0, input int y0, input int x1, input int y1, input int col);
    set_cmd(x0, y0, x1, y1, col);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ld_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    ld_done   = 1'b0;
    set_cmd(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ld_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%0d exp=0", ld_start); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (lines_drawn !== 16'd0) begin failures++; $display("FAIL reset_lines got=%0d exp=0", lines_drawn); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0d exp=0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0d exp=1", cmd_ready); end
    checks++; if ({ld_x0, ld_y0, ld_x1, ld_y1, ld_colour} !== 37'd0) begin failures++; $display("FAIL reset_cmd got=%0h exp=0", {ld_x0, ld_y0, ld_x1, ld_y1, ld_colour}); end
  endtask

  task automatic test_single();
    push(0, 0, 20, 15, 6);
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", fifo_count); end
    checks++; if (ld_start !== 1'b0) begin failures++; $display("FAIL single_early got=%0d exp=0", ld_start); end
    tick();
    checks++; if (ld_start !== 1'b1) begin failures++; $display("FAIL single_start got=%0d exp=1", ld_start); end
    checks++; if (ld_x1 !== 9'd20 || ld_y1 !== 8'd15 || ld_colour !== 3'd6) begin failures++; $display("FAIL single_cmd got=%0d,%0d,%0d exp=20,15,6", ld_x1, ld_y1, ld_colour); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%0d exp=1", busy); end
    // done raised while in START must be ignored
    ld_done = 1'b1;
    tick();
    checks++; if (ld_start !== 1'b1 || lines_drawn !== 16'd0) begin failures++; $display("FAIL done_in_start got=%0d,%0d exp=1,0", ld_start, lines_drawn); end
    tick();
    exp_lines++;
    checks++; if (ld_start !== 1'b0) begin failures++; $display("FAIL single_release got=%0d exp=0", ld_start); end
    checks++; if (lines_drawn !== 16'(exp_lines)) begin failures++; $display("FAIL single_lines got=%0d exp=%0d", lines_drawn, exp_lines); end
    ld_done = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%0d exp=0", busy); end
  endtask

  task automatic test_full();
    bit ok;
    for (int i = 1; i <= 5; i++) push(i, i, i + 10, i + 10, i);
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", fifo_count); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0d exp=0", cmd_ready); end
    checks++; if (ld_start !== 1'b1 || ld_x0 !== 9'd1) begin failures++; $display("FAIL full_first got=%0d,%0d exp=1,1", ld_start, ld_x0); end
    set_cmd(6, 6, 16, 16, 6);
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (fifo_count !== 3'd4 || cmd_ready !== 1'b0) begin failures++; $display("FAIL full_stall got=%0d,%0d exp=4,0", fifo_count, cmd_ready); end
    end
    ld_done = 1'b1;
    tick();
    exp_lines++;
    ld_done = 1'b0;
    tick();
    tick();
    checks++; if (fifo_count !== 3'd3 || cmd_ready !== 1'b1 || ld_x0 !== 9'd2) begin failures++; $display("FAIL full_pop got=%0d,%0d,%0d exp=3,1,2", fifo_count, cmd_ready, ld_x0); end
    tick();
    cmd_valid = 1'b0;
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL full_accept got=%0d exp=4", fifo_count); end
    for (int i = 2; i <= 6; i++) begin
      wait_start(ok);
      checks++; if (!ok) begin failures++; $display("FAIL full_timeout got=0 exp=1"); end
      checks++; if (ld_x0 !== 9'(i) || ld_colour !== 3'(i)) begin failures++; $display("FAIL full_order got=%0d,%0d exp=%0d", ld_x0, ld_colour, i); end
      tick();
      ld_done = 1'b1;
      tick();
      ld_done = 1'b0;
      tick();
      exp_lines++;
    end
    checks++; if (lines_drawn !== 16'(exp_lines)) begin failures++; $display("FAIL full_lines got=%0d exp=%0d", lines_drawn, exp_lines); end
  endtask

  task automatic test_done_held();
    bit ok;
    push(30, 1, 31, 2, 1);
    push(31, 3, 32, 4, 2);
    wait_start(ok);
    checks++; if (!ok || ld_x0 !== 9'd30) begin failures++; $display("FAIL held_first got=%0d,%0d exp=1,30", ok, ld_x0); end
    tick();
    ld_done = 1'b1;
    tick();
    exp_lines++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ld_start !== 1'b0 || lines_drawn !== 16'(exp_lines) || fifo_count !== 3'd1) begin failures++; $display("FAIL held_release got=%0d,%0d,%0d exp=0,%0d,1", ld_start, lines_drawn, fifo_count, exp_lines); end
    end
    ld_done = 1'b0;
    tick();
    checks++; if (ld_start !== 1'b0) begin failures++; $display("FAIL held_idle got=%0d exp=0", ld_start); end
    tick();
    checks++; if (ld_start !== 1'b1 || ld_x0 !== 9'd31) begin failures++; $display("FAIL held_next got=%0d,%0d exp=1,31", ld_start, ld_x0); end
    tick();
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    tick();
    exp_lines++;
    checks++; if (lines_drawn !== 16'(exp_lines)) begin failures++; $display("FAIL held_lines got=%0d exp=%0d", lines_drawn, exp_lines); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    push(40, 0, 41, 0, 1);
    push(41, 0, 42, 0, 2);
    push(42, 0, 43, 0, 3);
    checks++; if (ld_start !== 1'b1 || fifo_count !== 3'd2) begin failures++; $display("FAIL mid_pre got=%0d,%0d exp=1,2", ld_start, fifo_count); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ld_start !== 1'b0 || fifo_count !== 3'd0) begin failures++; $display("FAIL mid_async got=%0d,%0d exp=0,0", ld_start, fifo_count); end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || lines_drawn !== 16'd0) begin failures++; $display("FAIL mid_state got=%0d,%0d,%0d exp=0,1,0", busy, cmd_ready, lines_drawn); end
    exp_lines = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (ld_start !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_quiet got=%0d,%0d exp=0,0", ld_start, busy); end
    end
    push(50, 5, 51, 6, 7);
    tick();
    checks++; if (ld_start !== 1'b1 || ld_x0 !== 9'd50) begin failures++; $display("FAIL mid_new got=%0d,%0d exp=1,50", ld_start, ld_x0); end
    wait_start(ok);
    tick();
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    tick();
    exp_lines++;
    checks++; if (lines_drawn !== 16'(exp_lines)) begin failures++; $display("FAIL mid_lines got=%0d exp=%0d", lines_drawn, exp_lines); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int xs [3] = '{100, 200, 300};
    int ys [3] = '{10, 77, 119};
    int cs [3] = '{5, 2, 7};
    do_reset();
    exp_lines = 0;
    for (int i = 0; i < 3; i++) push(xs[i], i, xs[i] + 1, ys[i], cs[i]);
    for (int i = 0; i < 3; i++) begin
      wait_start(ok);
      checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout got=0 exp=1"); end
      checks++; if (ld_x0 !== 9'(xs[i]) || ld_y1 !== 8'(ys[i]) || ld_colour !== 3'(cs[i])) begin failures++; $display("FAIL b2b_order got=%0d,%0d,%0d exp=%0d,%0d,%0d", ld_x0, ld_y1, ld_colour, xs[i], ys[i], cs[i]); end
      tick();
      ld_done = 1'b1;
      tick();
      ld_done = 1'b0;
      tick();
      exp_lines++;
    end
    checks++; if (lines_drawn !== 16'd3) begin failures++; $display("FAIL b2b_lines got=%0d exp=3", lines_drawn); end
    checks++; if (busy !== 1'b0 || ld_start !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%0d,%0d exp=0,0", busy, ld_start); end
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    ld_done   = 1'b0;
    set_cmd(0, 0, 0, 0, 0);
    test_reset();
    test_single();
    test_full();
    test_done_held();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
